// File: rtl/tilemap_write_arbiter.sv
// Write-port arbiter for the tile-map RAM: round-robin between two requesters,
// commits only inside the write window, and can fill the whole map with a constant.
module tilemap_write_arbiter #(
    parameter int                ADDR_W      = 5,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
    parameter bit                BLANK_ONLY  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_blank,
    input  logic              i_clear,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_address,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_address,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    output logic [ADDR_W-1:0] o_ram_address,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_wren,
    output logic              o_busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clear_cnt_reg, clear_cnt_next;
    logic              last1_reg, last1_next;
    logic [ADDR_W-1:0] ram_address_reg, ram_address_next;
    logic [DATA_W-1:0] ram_data_reg, ram_data_next;
    logic              ram_wren_reg, ram_wren_next;
    logic              busy_reg, busy_next;
    logic              window;
    logic              grant0, grant1;

    assign window = BLANK_ONLY ? i_blank : 1'b1;

    always_comb begin
        state_next       = state_reg;
        clear_cnt_next   = clear_cnt_reg;
        last1_next       = last1_reg;
        ram_address_next = ram_address_reg;
        ram_data_next    = ram_data_reg;
        ram_wren_next    = 1'b0;
        busy_next        = busy_reg;
        grant0           = 1'b0;
        grant1           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_clear) begin
                    state_next     = CLEAR;
                    clear_cnt_next = '0;
                    busy_next      = 1'b1;
                end else if (window) begin
                    // Requester 0 wins contention only if requester 1 was served last.
                    if (i_req0_valid && (!i_req1_valid || last1_reg)) begin
                        grant0 = 1'b1;
                    end else if (i_req1_valid) begin
                        grant1 = 1'b1;
                    end

                    if (grant0) begin
                        ram_wren_next    = 1'b1;
                        ram_address_next = i_req0_address;
                        ram_data_next    = i_req0_data;
                        last1_next       = 1'b0;
                    end else if (grant1) begin
                        ram_wren_next    = 1'b1;
                        ram_address_next = i_req1_address;
                        ram_data_next    = i_req1_data;
                        last1_next       = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (window) begin
                    ram_wren_next    = 1'b1;
                    ram_address_next = clear_cnt_reg;
                    ram_data_next    = CLEAR_VALUE;
                    clear_cnt_next   = clear_cnt_reg + 1'b1;
                    if (clear_cnt_reg == {ADDR_W{1'b1}}) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            clear_cnt_reg   <= '0;
            last1_reg       <= 1'b1;
            ram_address_reg <= '0;
            ram_data_reg    <= '0;
            ram_wren_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            clear_cnt_reg   <= clear_cnt_next;
            last1_reg       <= last1_next;
            ram_address_reg <= ram_address_next;
            ram_data_reg    <= ram_data_next;
            ram_wren_reg    <= ram_wren_next;
            busy_reg        <= busy_next;
        end
    end

    assign o_req0_ready  = grant0 & ~i_rst;
    assign o_req1_ready  = grant1 & ~i_rst;
    assign o_ram_address = ram_address_reg;
    assign o_ram_data    = ram_data_reg;
    assign o_ram_wren    = ram_wren_reg;
    assign o_busy        = busy_reg;

endmodule

// File: tb/tb_tilemap_write_arbiter.sv
// Directed bench for tilemap_write_arbiter: grants, round-robin, windowing,
// clear sequencing and reset abort, all against hand-computed expectations.
module tb_tilemap_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       blank;
    logic       clear;
    logic       req0_valid;
    logic [4:0] req0_address;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [4:0] req1_address;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tilemap_write_arbiter #(
        .ADDR_W(5), .DATA_W(8), .CLEAR_VALUE(8'h00), .BLANK_ONLY(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_blank(blank), .i_clear(clear),
        .i_req0_valid(req0_valid), .i_req0_address(req0_address),
        .i_req0_data(req0_data), .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_address(req1_address),
        .i_req1_data(req1_data), .o_req1_ready(req1_ready),
        .o_ram_address(ram_address), .o_ram_data(ram_data),
        .o_ram_wren(ram_wren), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_addr;
        int cyc;
        logic blank_now;

        rst = 1'b1; blank = 1'b1; clear = 1'b0;
        req0_valid = 1'b1; req0_address = 5'd3; req0_data = 8'hA5;
        req1_valid = 1'b0; req1_address = 5'd0; req1_data = 8'h00;
        tick(); tick();

        // Reset state; ready must stay low while reset is held
        chk("rst_wren", ram_wren, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", req0_ready, 0);
        $display("reset checked");

        // Single write from requester 0
        rst = 1'b0;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        tick();
        chk("single_wren", ram_wren, 1);
        chk("single_addr", ram_address, 3);
        chk("single_data", ram_data, 8'hA5);
        $display("single write addr=%0d data=%h wren=%b", ram_address, ram_data, ram_wren);
        req0_valid = 1'b0;

        // Re-reset so the pointer is back at "requester 1 served last"
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_address = 5'd4; req0_data = 8'h40;
        req1_valid = 1'b1; req1_address = 5'd9; req1_data = 8'h90;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_wren", ram_wren, 1);
            chk("rr_addr", ram_address, (i % 2 == 0) ? 4 : 9);
            chk("rr_data", ram_data, (i % 2 == 0) ? 8'h40 : 8'h90);
            $display("rr cycle %0d addr=%0d data=%h", i, ram_address, ram_data);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Requester 1 outside the window: no grant until blank rises
        blank = 1'b0;
        req1_valid = 1'b1; req1_address = 5'd7; req1_data = 8'h77;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("noblank_ready1", req1_ready, 0);
            tick();
            chk("noblank_wren", ram_wren, 0);
        end
        blank = 1'b1;
        #1;
        chk("blank_ready1", req1_ready, 1);
        tick();
        chk("blank_wren", ram_wren, 1);
        chk("blank_addr", ram_address, 7);
        chk("blank_data", ram_data, 8'h77);
        $display("windowed write addr=%0d data=%h", ram_address, ram_data);
        req1_valid = 1'b0;

        // Clear with the window held open; a pending request must wait
        req0_valid = 1'b1; req0_address = 5'd5; req0_data = 8'h55;
        clear = 1'b1;
        #1;
        chk("clear_pulse_ready0", req0_ready, 0);
        tick();
        clear = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk("clear_busy", busy, 1);
            chk("clear_ready0", req0_ready, 0);
            chk("clear_ready1", req1_ready, 0);
            tick();
            chk("clear_wren", ram_wren, 1);
            chk("clear_addr", ram_address, c);
            chk("clear_data", ram_data, 8'h00);
        end
        chk("clear_done_busy", busy, 0);
        chk("after_clear_ready0", req0_ready, 1);
        tick();
        chk("after_clear_addr", ram_address, 5);
        chk("after_clear_data", ram_data, 8'h55);
        $display("full clear done, pending write addr=%0d data=%h", ram_address, ram_data);
        req0_valid = 1'b0;

        // Clear with the window toggling every 4 cycles plus a stray clear mid-sequence
        clear = 1'b1; tick(); clear = 1'b0;
        chk("toggle_busy", busy, 1);
        exp_addr = 0;
        cyc = 0;
        while (exp_addr < 32 && cyc < 200) begin
            blank_now = (((cyc >> 2) & 1) == 0);
            blank = blank_now;
            clear = (cyc == 5);
            tick();
            if (blank_now) begin
                chk("toggle_wren", ram_wren, 1);
                chk("toggle_addr", ram_address, exp_addr);
                exp_addr++;
            end else begin
                chk("toggle_idle_wren", ram_wren, 0);
            end
            cyc++;
        end
        clear = 1'b0;
        chk("toggle_count", exp_addr, 32);
        chk("toggle_done_busy", busy, 0);
        $display("toggled clear finished after %0d cycles", cyc);
        blank = 1'b1;

        // Reset aborts a clear at address 10
        clear = 1'b1; tick(); clear = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("abort_last_addr", ram_address, 9);
        rst = 1'b1;
        req0_valid = 1'b1; req0_address = 5'd12; req0_data = 8'hC3;
        #1;
        chk("abort_rst_ready0", req0_ready, 0);
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_wren", ram_wren, 0);
        rst = 1'b0;
        #1;
        chk("abort_ready0", req0_ready, 1);
        tick();
        chk("abort_req_wren", ram_wren, 1);
        chk("abort_req_addr", ram_address, 12);
        chk("abort_req_data", ram_data, 8'hC3);
        req0_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_quiet_wren", ram_wren, 0);
            chk("abort_quiet_busy", busy, 0);
        end
        $display("reset abort checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tilemap_write_arbiter.md
# tilemap_write_arbiter

Arbitrates write access to the control-side port of the 32-entry tile-map RAM (RAM_2PORT, 5-bit address, 8-bit data) between two requesters: the game controller and a score/overlay writer. Writes are committed only during the display blanking window, so layer1 never fetches a half-updated tile map mid-frame. A built-in clear sequencer can fill the whole map with a constant value. The block sits between the requesters and the RAM write port, and is clocked on the system clock.

## Interface
Parameters:
- ADDR_W, 5: tile-map address width; map depth is 2^ADDR_W.
- DATA_W, 8: tile-map entry width.
- CLEAR_VALUE, 8'h00: value written to every entry by a clear sequence.
- BLANK_ONLY, 1: 1 = commit writes only while i_blank=1; 0 = commit writes in any cycle.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_blank  in  1  display blanking window, already synchronous to i_clk.
- i_clear  in  1  single-cycle pulse that starts a full-map clear.
- i_req0_valid  in  1  requester 0 (game controller) has a write pending.
- i_req0_address  in  ADDR_W  requester 0 write address.
- i_req0_data  in  DATA_W  requester 0 write data.
- o_req0_ready  out  1  requester 0 write accepted in this cycle (combinational).
- i_req1_valid / i_req1_address / i_req1_data / o_req1_ready: same as requester 0, for the overlay writer.
- o_ram_address  out  ADDR_W  registered RAM write address.
- o_ram_data  out  DATA_W  registered RAM write data.
- o_ram_wren  out  1  registered RAM write enable.
- o_busy  out  1  registered; high while a clear is in progress.

## Operation
- Write window: window = i_blank when BLANK_ONLY=1; window = 1 when BLANK_ONLY=0.
- FSM states: IDLE, CLEAR.
- IDLE:
  - i_clear=1 moves the FSM to CLEAR, resets the clear counter to 0 and sets o_busy=1. Clear takes priority over requests: neither ready is asserted in that cycle.
  - Otherwise, if window=1, at most one requester is granted.
  - Only one requester valid: that requester is granted.
  - Both requesters valid: round-robin. The requester not served last is granted.
  - A grant asserts o_reqN_ready=1 in the same cycle. Handshake completes when valid and ready are both 1.
- Round-robin pointer:
  - Updated only on a completed handshake.
  - Reset value points to requester 1 as last served, so requester 0 wins the first contention.
- Accepted write: on the next edge, o_ram_address and o_ram_data take the granted address and data, and o_ram_wren=1 for exactly one cycle per handshake.
- CLEAR:
  - Each cycle with window=1 writes CLEAR_VALUE to the address given by the counter, then increments the counter.
  - Cycles with window=0 stall the sequence: no write, counter held.
  - After the write to address 2^ADDR_W-1, the FSM returns to IDLE and o_busy drops on the same edge as that write's registration.
  - Both ready outputs are 0 throughout CLEAR.
  - i_clear received during CLEAR is ignored; the sequence does not restart.
- Requesters must hold valid, address and data stable until ready. The arbiter does not buffer requests.
- No address collision checks. Two writes to the same address are committed in grant order.

## Timing
- Reset values (registered outputs): o_ram_wren=0, o_ram_address=0, o_ram_data=0, o_busy=0, FSM=IDLE, clear counter=0, round-robin pointer = requester 1.
- Ready outputs are combinational and are 0 while i_rst=1.
- Latency: handshake in cycle N produces o_ram_wren=1 in cycle N+1 with the matching address and data.
- Throughput: one write per cycle while window=1. Two continuously valid requesters alternate 0,1,0,1,...
- Window closing: when i_blank falls, no grant is issued from that cycle onward. A write registered on the previous edge still completes.
- Clear duration: 2^ADDR_W windowed cycles, i.e. 32 cycles when uninterrupted.
  - o_busy rises the cycle after the i_clear pulse.
  - The first clear write (address 0) appears in the cycle after the first windowed cycle spent in CLEAR.
- Reset mid-operation: i_rst during CLEAR aborts it. The next cycle is IDLE with o_busy=0 and o_ram_wren=0, and no further clear writes occur.
- Simultaneous events:
  - i_clear together with a valid request: clear wins and the request stays pending.
  - i_clear with window=0: the clear is still registered and waits for the window.

## Test plan
- Reset, i_blank=1, req0 valid with address 5'd3 and data 8'hA5 → o_req0_ready=1 in the same cycle; next cycle o_ram_wren=1, o_ram_address=3, o_ram_data=A5.
- Both requesters valid for 4 cycles with i_blank=1 → grants in order 0,1,0,1 and four consecutive o_ram_wren pulses carrying the matching data.
- BLANK_ONLY=1, req1 valid with i_blank=0 for 10 cycles, then i_blank=1 → no ready and no wren during those 10 cycles; ready is asserted in the first blank cycle.
- i_clear pulse with i_blank=1 held → o_busy=1 for 32 cycles; addresses 0..31 each written once with 8'h00; both ready outputs stay 0 throughout, even with requesters valid.
- Clear with i_blank toggling every 4 cycles → writes occur only in windowed cycles, no address is skipped or repeated, and the sequence ends after the write to address 31.
- i_rst asserted at clear address 10 → next cycle o_busy=0 and o_ram_wren=0; a following req0 is served normally.
